game_input_ctrl: RTL
====================

# game_input_ctrl

Front end that drives the `start` and `jump` inputs of the Game core from raw board push-buttons. It synchronizes and debounces both buttons and converts presses into single, state-qualified commands. It tracks run state from the core's `game_over` so that starts are accepted only when idle or over, and jumps only while running. It sits between the board button pins and Game, in the `game_clk` domain.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 4: consecutive `game_clk` cycles a synchronized button level must differ from the debounced level before the debounced level flips; legal range 1–255.
- `JUMP_HOLD`, 2: number of cycles `jump` stays high per accepted press; legal range 1–15.
- `OVER_GUARD`, 2: cycles after entering RUN during which `game_over` is ignored.

Ports:
- `game_clk`, in, 1: game clock. All logic is on its rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `btn_jump`, in, 1: raw jump button, asynchronous, active-high.
- `btn_start`, in, 1: raw start button, asynchronous, active-high.
- `game_over`, in, 1: from Game, level.
- `start`, out, 1: one-cycle start command to Game (registered).
- `jump`, out, 1: jump command to Game, high for `JUMP_HOLD` cycles (registered).
- `run_state`, out, 2: 00 = IDLE, 01 = RUN, 10 = OVER; 11 is never driven.
- `jump_count`, out, 8: accepted jumps in the current game, saturating.

## Operation
- **Reset** (`rst_n` = 0 at an edge): all synchronizer flops, debounced levels and debounce counters go to 0; FSM goes to IDLE.
  - Outputs after reset: `start` = 0, `jump` = 0, `run_state` = 00, `jump_count` = 0.
  - Reset mid-jump or mid-debounce discards all in-progress state.
- **Synchronizer:** 2-flop synchronizer per button.
- **Debounce:** one counter per button.
  - Increments while the synchronized value differs from the debounced level; clears to 0 on any agreeing cycle.
  - On reaching `DEBOUNCE_CYCLES`, the debounced level flips and the counter clears.
- **Press event:** one-cycle pulse on a debounced 0→1 transition. Release (1→0) produces no event. Holding a button yields exactly one press.
- **FSM:**
  - IDLE: a start press drives `start` = 1 for one cycle → RUN. Jump presses are ignored.
  - RUN: a jump press with `jump` low and hold counter idle is accepted.
    - On acceptance: `jump` = 1 for `JUMP_HOLD` cycles; `jump_count` += 1, saturating at 255.
    - A jump press while `jump` is high is dropped (not queued).
    - Start presses are ignored.
    - `game_over` = 1 with the guard expired → OVER.
  - OVER: a start press drives a `start` pulse → RUN and clears `jump_count` to 0 in the same edge. Jump presses are ignored.
- **Guard counter:** loads `OVER_GUARD` on every RUN entry and counts down to 0. `game_over` is honored only when it reads 0, so a stale `game_over` from the previous game cannot bounce the FSM back to OVER.
- **Simultaneous events:**
  - Start and jump press in the same cycle in IDLE/OVER: start only; the jump is dropped.
  - `game_over` and a jump press in the same cycle in RUN: `game_over` wins. Go to OVER, no jump accepted, `jump_count` unchanged.
  - Entering OVER while `jump` is high: `jump` drops at the same edge and the remaining hold is cancelled.

## Timing
- Pipeline latency: button first sampled high at edge k → `start`/`jump` first high after edge k + 3 + `DEBOUNCE_CYCLES` (edge k+7 with defaults).
- Breakdown: 2 synchronizer edges, `DEBOUNCE_CYCLES` debounce edges, 1 output register edge.
- `run_state` changes at the same edge where `start` rises or where `game_over` is honored.
- `start` is high for exactly 1 cycle per accepted press.
- `jump` is high for exactly `JUMP_HOLD` consecutive cycles unless cut short by OVER.
- A glitch shorter than `DEBOUNCE_CYCLES` cycles (after synchronization) produces no event.
- Throughput: one accepted jump per `JUMP_HOLD` + `DEBOUNCE_CYCLES` × 2 cycles minimum, since the button must debounce low and then high again.

## Test plan
1. **Reset and start:** `rst_n` low 2 cycles, then `btn_start` high 10 cycles.
   - `start` high for exactly 1 cycle at edge 7.
   - `run_state` 00→01 at that edge; `jump_count` = 0.
2. **Jump:** in RUN, `btn_jump` high 10 cycles.
   - `jump` high for exactly 2 cycles starting 7 edges after the press.
   - `jump_count` = 1; the held button produces no second jump.
3. **Glitch rejection:** `btn_jump` high for 3 cycles, then low.
   - `jump` stays 0; `jump_count` unchanged.
4. **Game over mid-jump and restart:**
   - `game_over` = 1 while `jump` is high → `jump` drops the same edge, `run_state` = 10.
   - Subsequent jump press is ignored.
   - Start press with `game_over` still high for 1 more cycle → `run_state` = 01 and stays 01 (guard); `jump_count` clears to 0.
5. **Simultaneous presses:** in IDLE, both buttons rise together.
   - Only `start` pulses; `jump` stays 0; `jump_count` = 0.
6. **Saturation:** 260 accepted jumps in RUN → `jump_count` holds at 255.

Source files
------------

// File: rtl/game_input_ctrl.sv
// Button front end for the Game core: synchronizes and debounces the start/jump
// buttons and turns presses into run-state-qualified start/jump commands.
module game_input_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned JUMP_HOLD       = 2,
  parameter int unsigned OVER_GUARD      = 2
) (
  input  logic       game_clk,
  input  logic       rst_n,
  input  logic       btn_jump,
  input  logic       btn_start,
  input  logic       game_over,
  output logic       start,
  output logic       jump,
  output logic [1:0] run_state,
  output logic [7:0] jump_count
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    OVER = 2'b10
  } state_t;

  localparam logic [7:0] DB_LAST    = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] HOLD_LAST  = 4'(JUMP_HOLD - 1);
  localparam logic [7:0] GUARD_INIT = 8'(OVER_GUARD);

  // Bit 0 carries the jump button, bit 1 the start button.
  logic [1:0] btn;
  logic [1:0] sync_1;
  logic [1:0] sync_2;
  logic [1:0] level;
  logic [1:0] level_d;
  logic [1:0] press;
  logic [7:0] db_cnt [2];

  assign btn = {btn_start, btn_jump};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      always_ff @(posedge game_clk) begin
        if (!rst_n) begin
          sync_1[gi]  <= 1'b0;
          sync_2[gi]  <= 1'b0;
          level[gi]   <= 1'b0;
          level_d[gi] <= 1'b0;
          press[gi]   <= 1'b0;
          db_cnt[gi]  <= 8'd0;
        end else begin
          sync_1[gi]  <= btn[gi];
          sync_2[gi]  <= sync_1[gi];
          level_d[gi] <= level[gi];
          // Registered rising-edge detect keeps press glitch-free for the FSM.
          press[gi]   <= level[gi] & ~level_d[gi];
          if (sync_2[gi] != level[gi]) begin
            if (db_cnt[gi] == DB_LAST) begin
              level[gi]  <= sync_2[gi];
              db_cnt[gi] <= 8'd0;
            end else begin
              db_cnt[gi] <= db_cnt[gi] + 8'd1;
            end
          end else begin
            db_cnt[gi] <= 8'd0;
          end
        end
      end
    end
  endgenerate

  logic       jump_press;
  logic       start_press;
  state_t     state;
  logic [3:0] hold_cnt;
  logic [7:0] guard_cnt;

  assign jump_press  = press[0];
  assign start_press = press[1];
  assign run_state   = state;

  always_ff @(posedge game_clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      start      <= 1'b0;
      jump       <= 1'b0;
      jump_count <= 8'd0;
      hold_cnt   <= 4'd0;
      guard_cnt  <= 8'd0;
    end else begin
      start <= 1'b0;
      case (state)
        IDLE, OVER: begin
          // A simultaneous jump press is simply not looked at here.
          if (start_press) begin
            start      <= 1'b1;
            state      <= RUN;
            guard_cnt  <= GUARD_INIT;
            jump_count <= 8'd0;
          end
        end
        RUN: begin
          if (guard_cnt != 8'd0) begin
            guard_cnt <= guard_cnt - 8'd1;
          end
          if ((guard_cnt == 8'd0) && game_over) begin
            state    <= OVER;
            jump     <= 1'b0;
            hold_cnt <= 4'd0;
          end else if (jump) begin
            if (hold_cnt == 4'd0) begin
              jump <= 1'b0;
            end else begin
              hold_cnt <= hold_cnt - 4'd1;
            end
          end else if (jump_press) begin
            jump     <= 1'b1;
            hold_cnt <= HOLD_LAST;
            if (jump_count != 8'hFF) begin
              jump_count <= jump_count + 8'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
          jump  <= 1'b0;
        end
      endcase
    end
  end

endmodule
